// File: rtl/csr_pwm_outpins.sv
// csr_pwm_outpins: CSR-mapped PWM output block.
// Each channel has a shadow duty register that is copied into the active
// duty only at a period wrap, so outputs never glitch mid-period. All
// channels share one prescaler and one phase counter.
module csr_pwm_outpins #(
   parameter int          CHANNELS       = 4,
   parameter int          WIDTH          = 8,
   parameter int          PRESCALE_WIDTH = 16,
   parameter logic [11:0] BASE_ADDR      = 12'hBC4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                read,
   input  logic [2:0]          modify,
   input  logic [31:0]         wdata,
   input  logic [11:0]         addr,
   output logic [31:0]         rdata,
   output logic                valid,
   output logic [CHANNELS-1:0] outpins,
   output logic                period_irq
);

   // Last phase value of a period; the period is 2^WIDTH-1 ticks long.
   localparam logic [WIDTH-1:0] PHASE_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [11:0]      LAST_OFFSET = 12'(CHANNELS + 1);

   // Architectural state
   logic [CHANNELS-1:0]       en_q, en_d;
   logic                      run_q, run_d;
   logic                      ie_q, ie_d;
   logic [7:0]                wraps_q, wraps_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
   logic [WIDTH-1:0]          phase_q, phase_d;
   logic [WIDTH-1:0]          shadow_q [CHANNELS];
   logic [WIDTH-1:0]          shadow_d [CHANNELS];
   logic [WIDTH-1:0]          active_q [CHANNELS];
   logic [WIDTH-1:0]          active_d [CHANNELS];
   logic [CHANNELS-1:0]       out_q, out_d;
   logic                      irq_q, irq_d;

   // Bus decode
   logic [11:0] offset;
   logic        hit;
   logic        op_valid;
   logic        write_en;
   logic        prescale_wr;
   logic [31:0] reg_value;
   logic [31:0] new_value;
   logic        tick;
   logic        wrap;
   logic        unused_new_bits;

   function automatic logic [31:0] apply_op(input logic [2:0]  op,
                                            input logic [31:0] old_v,
                                            input logic [31:0] operand);
      case (op)
         3'd1:    return operand;
         3'd2:    return old_v | operand;
         3'd3:    return old_v & ~operand;
         default: return old_v;
      endcase
   endfunction

   // Address decode, register readback mux and read-modify-write result.
   always_comb begin
      offset   = addr - BASE_ADDR;
      hit      = (offset <= LAST_OFFSET);
      op_valid = (modify == 3'd1) || (modify == 3'd2) || (modify == 3'd3);
      write_en = hit && op_valid;
      reg_value = 32'd0;
      if (offset == 12'd0) begin
         reg_value = {wraps_q, 6'd0, ie_q, run_q, 16'(en_q)};
      end else if (offset == 12'd1) begin
         reg_value = 32'(prescale_q);
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (offset == 12'(i + 2)) begin
            reg_value = 32'(shadow_q[i]);
         end
      end
      new_value = apply_op(modify, reg_value, wdata);
   end

   // Upper operand bits have no register behind them.
   assign unused_new_bits = ^new_value;

   assign valid = hit && (read || op_valid);
   assign rdata = valid ? reg_value : 32'd0;

   // Next-state: CSR writes, prescaler, phase counter and period wrap.
   always_comb begin
      en_d        = en_q;
      run_d       = run_q;
      ie_d        = ie_q;
      prescale_d  = prescale_q;
      shadow_d    = shadow_q;
      prescale_wr = 1'b0;
      if (write_en) begin
         if (offset == 12'd0) begin
            en_d  = new_value[CHANNELS-1:0];
            run_d = new_value[16];
            ie_d  = new_value[17];
         end else if (offset == 12'd1) begin
            prescale_d  = new_value[PRESCALE_WIDTH-1:0];
            prescale_wr = 1'b1;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (offset == 12'(i + 2)) begin
               shadow_d[i] = new_value[WIDTH-1:0];
            end
         end
      end

      tick = run_q && (presc_cnt_q == '0);
      wrap = tick && (phase_q == PHASE_LAST);

      // While stopped the counter idles at 0; starting loads the full
      // prescale so phase 0 lasts a whole tick interval like every phase.
      if (!run_q) begin
         presc_cnt_d = run_d ? prescale_d : '0;
      end else if (prescale_wr) begin
         presc_cnt_d = prescale_d;
      end else if (tick) begin
         presc_cnt_d = prescale_q;
      end else begin
         presc_cnt_d = presc_cnt_q - PRESCALE_WIDTH'(1);
      end

      if (!run_q || wrap) begin
         phase_d = '0;
      end else if (tick) begin
         phase_d = phase_q + WIDTH'(1);
      end else begin
         phase_d = phase_q;
      end

      // Active duty takes the pre-write shadow, so a DUTY write landing on
      // the wrap edge only becomes active one period later.
      for (int i = 0; i < CHANNELS; i++) begin
         active_d[i] = (!run_q || wrap) ? shadow_q[i] : active_q[i];
      end

      wraps_d = wraps_q + {7'd0, wrap};
      irq_d   = wrap && ie_q;
   end

   // Per-channel compare against the current phase.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign out_d[gi] = run_q && en_q[gi] && (phase_q < active_q[gi]);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         en_q        <= '0;
         run_q       <= 1'b0;
         ie_q        <= 1'b0;
         wraps_q     <= '0;
         prescale_q  <= '0;
         presc_cnt_q <= '0;
         phase_q     <= '0;
         out_q       <= '0;
         irq_q       <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         en_q        <= en_d;
         run_q       <= run_d;
         ie_q        <= ie_d;
         wraps_q     <= wraps_d;
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
         phase_q     <= phase_d;
         out_q       <= out_d;
         irq_q       <= irq_d;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   assign outpins    = out_q;
   assign period_irq = irq_q;

endmodule

// File: tb/tb_csr_pwm_outpins.sv
// tb_csr_pwm_outpins: self-checking bench for csr_pwm_outpins.
// The reference model tracks the position inside the PWM period in clocks
// and derives the phase as position / (PRESCALE+1).
module tb_csr_pwm_outpins;

   localparam int          CH     = 4;
   localparam logic [11:0] BASE   = 12'hBC4;
   localparam logic [11:0] A_CTRL = BASE;
   localparam logic [11:0] A_PRE  = BASE + 12'd1;
   localparam logic [11:0] A_D0   = BASE + 12'd2;
   localparam logic [11:0] A_D1   = BASE + 12'd3;
   localparam logic [11:0] A_D2   = BASE + 12'd4;

   logic          clk;
   logic          rstn;
   logic          read;
   logic [2:0]    modify;
   logic [31:0]   wdata;
   logic [11:0]   addr;
   logic [31:0]   rdata;
   logic          valid;
   logic [CH-1:0] outpins;
   logic          period_irq;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   logic [CH-1:0] m_en    = '0;
   logic          m_run   = 1'b0;
   logic          m_ie    = 1'b0;
   logic [7:0]    m_wraps = '0;
   logic [15:0]   m_pre   = '0;
   logic [7:0]    m_shadow [CH];
   logic [7:0]    m_active [CH];
   int            m_pos   = 0;
   logic [CH-1:0] m_out   = '0;
   logic          m_irq   = 1'b0;

   csr_pwm_outpins #(
      .CHANNELS(CH), .WIDTH(8), .PRESCALE_WIDTH(16), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
      .addr(addr), .rdata(rdata), .valid(valid), .outpins(outpins),
      .period_irq(period_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_hit(input logic [11:0] a);
      return (a >= BASE) && (a <= BASE + 12'd5);
   endfunction

   function automatic logic [31:0] m_reg(input logic [11:0] a);
      if (a == A_CTRL) return {m_wraps, 6'd0, m_ie, m_run, 12'd0, m_en};
      if (a == A_PRE)  return {16'd0, m_pre};
      for (int i = 0; i < CH; i++)
         if (a == A_D0 + 12'(i)) return {24'd0, m_shadow[i]};
      return 32'd0;
   endfunction

   // Advance the model by one clock using the inputs currently driven,
   // then let the DUT take the same edge.
   task automatic step();
      logic [CH-1:0] nout;
      logic          nirq;
      logic [31:0]   old_v, nv;
      int            per, ticklen;
      if (!rstn) begin
         m_en = '0; m_run = 1'b0; m_ie = 1'b0; m_wraps = '0; m_pre = '0;
         m_pos = 0; m_out = '0; m_irq = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
         end
      end else begin
         ticklen = int'(m_pre) + 1;
         per     = ticklen * 255;
         for (int i = 0; i < CH; i++)
            nout[i] = m_run && m_en[i] && ((m_pos / ticklen) < int'(m_active[i]));
         nirq = 1'b0;
         if (m_run) begin
            if (m_pos + 1 == per) begin
               m_pos = 0;
               m_wraps = m_wraps + 8'd1;
               nirq = m_ie;
               for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
            end else begin
               m_pos = m_pos + 1;
            end
         end else begin
            m_pos = 0;
            for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
         end
         if (m_hit(addr) && modify >= 3'd1 && modify <= 3'd3) begin
            old_v = m_reg(addr);
            case (modify)
               3'd1:    nv = wdata;
               3'd2:    nv = old_v | wdata;
               default: nv = old_v & ~wdata;
            endcase
            if (addr == A_CTRL) begin
               m_en = nv[CH-1:0]; m_run = nv[16]; m_ie = nv[17];
            end else if (addr == A_PRE) begin
               m_pre = nv[15:0];
            end else begin
               m_shadow[int'(addr - A_D0)] = nv[7:0];
            end
         end
         m_out = nout;
         m_irq = nirq;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
      modify = op; addr = a; wdata = d;
      step();
      modify = 3'd0;
   endtask

   // Observe n clocks: high cycles of channel ch, irq pulses, model mismatches.
   task automatic count_window(input int n, input int ch, output int hi,
                               output int irqs, output int mism);
      hi = 0; irqs = 0; mism = 0;
      for (int c = 0; c < n; c++) begin
         step();
         if (outpins[ch]) hi++;
         if (period_irq) irqs++;
         if (outpins !== m_out || period_irq !== m_irq) mism++;
      end
   endtask

   // Length of the next complete high run on channel 0, -1 on timeout.
   task automatic measure_run(output int len);
      int k;
      len = -1; k = 0;
      while (outpins[0] && k < 2000) begin step(); k++; end
      while (!outpins[0] && k < 2000) begin step(); k++; end
      if (k >= 2000) return;
      len = 0;
      while (outpins[0] && k < 2000) begin len++; step(); k++; end
      if (k >= 2000) len = -1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; read = 1'b1; addr = A_CTRL; modify = 3'd0; wdata = '0;
      step(); step();
      n_total++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
      n_total++; if (valid !== 1'b1) $display("FAIL reset_valid: got %b expected 1", valid); else n_pass++;
      n_total++; if (outpins !== '0) $display("FAIL reset_outpins: got %b expected 0", outpins); else n_pass++;
      n_total++; if (period_irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", period_irq); else n_pass++;
      rstn = 1'b1;
      step();
      $display("test_reset done");
   endtask

   task automatic test_csr_ops();
      csr(3'd1, A_PRE, 32'h0001_2345);
      read = 1'b1; addr = A_PRE; #1;
      n_total++; if (rdata !== 32'h0000_2345) $display("FAIL prescale_mask: got %h expected 00002345", rdata); else n_pass++;
      csr(3'd1, A_PRE, 32'd0);
      csr(3'd4, A_D0, 32'hFF);
      read = 1'b1; addr = A_D0; #1;
      n_total++; if (rdata !== 32'd0) $display("FAIL modify4_ignored: got %h expected 0", rdata); else n_pass++;
      read = 1'b0; modify = 3'd4; #1;
      n_total++; if (valid !== 1'b0) $display("FAIL valid_no_op: got %b expected 0", valid); else n_pass++;
      modify = 3'd0;
      csr(3'd1, A_CTRL, 32'h0003_0005);
      csr(3'd2, A_CTRL, 32'h0000_0002);
      csr(3'd3, A_CTRL, 32'h0000_0001);
      read = 1'b1; addr = A_CTRL; #1;
      n_total++; if (rdata !== 32'h0003_0006) $display("FAIL ctrl_rmw: got %h expected 00030006", rdata); else n_pass++;
      addr = BASE + 12'd6; #1;
      n_total++; if (valid !== 1'b0 || rdata !== 32'd0) $display("FAIL out_of_range: got valid=%b rdata=%h expected 0/0", valid, rdata); else n_pass++;
      addr = A_CTRL; modify = 3'd1; wdata = 32'h0000_0000; #1;
      n_total++; if (rdata !== 32'h0003_0006) $display("FAIL read_old_on_write: got %h expected 00030006", rdata); else n_pass++;
      step(); modify = 3'd0;
      $display("test_csr_ops done");
   endtask

   task automatic test_duty();
      int hi, irqs, mism, mism_all;
      csr(3'd1, A_CTRL, 32'd0);
      csr(3'd1, A_PRE, 32'd0);
      csr(3'd1, A_D0, 32'd64);
      csr(3'd1, A_CTRL, 32'h0001_0001);
      step(); step();
      count_window(255, 0, hi, irqs, mism); mism_all = mism;
      n_total++; if (hi != 64) $display("FAIL duty64_high: got %0d expected 64", hi); else n_pass++;
      csr(3'd1, A_D0, 32'd0);
      repeat (300) step();
      count_window(255, 0, hi, irqs, mism); mism_all += mism;
      n_total++; if (hi != 0) $display("FAIL duty0_high: got %0d expected 0", hi); else n_pass++;
      csr(3'd1, A_D0, 32'd255);
      repeat (300) step();
      count_window(255, 0, hi, irqs, mism); mism_all += mism;
      n_total++; if (hi != 255) $display("FAIL duty255_high: got %0d expected 255", hi); else n_pass++;
      n_total++; if (mism_all != 0) $display("FAIL duty_trace: got %0d mismatching cycles expected 0", mism_all); else n_pass++;
      $display("test_duty done");
   endtask

   task automatic test_prescaler();
      int hi, irqs, mism;
      csr(3'd1, A_CTRL, 32'd0);
      csr(3'd1, A_PRE, 32'd3);
      csr(3'd1, A_D1, 32'd10);
      csr(3'd1, A_CTRL, 32'h0003_0002);
      step(); step();
      count_window(1020, 1, hi, irqs, mism);
      n_total++; if (hi != 40) $display("FAIL presc_high: got %0d expected 40", hi); else n_pass++;
      n_total++; if (irqs != 1) $display("FAIL presc_irq_ie1: got %0d expected 1", irqs); else n_pass++;
      n_total++; if (mism != 0) $display("FAIL presc_trace_a: got %0d mismatching cycles expected 0", mism); else n_pass++;
      csr(3'd3, A_CTRL, 32'h0002_0000);
      count_window(1020, 1, hi, irqs, mism);
      n_total++; if (irqs != 0) $display("FAIL presc_irq_ie0: got %0d expected 0", irqs); else n_pass++;
      n_total++; if (mism != 0) $display("FAIL presc_trace_b: got %0d mismatching cycles expected 0", mism); else n_pass++;
      read = 1'b1; addr = A_CTRL; #1;
      n_total++; if (rdata !== m_reg(A_CTRL)) $display("FAIL presc_wraps: got %h expected %h", rdata, m_reg(A_CTRL)); else n_pass++;
      $display("test_prescaler done");
   endtask

   task automatic test_glitch_free();
      int run_len, len, k;
      csr(3'd1, A_CTRL, 32'd0);
      csr(3'd1, A_PRE, 32'd0);
      csr(3'd1, A_D0, 32'd64);
      csr(3'd1, A_CTRL, 32'h0001_0001);
      k = 0;
      while (!outpins[0] && k < 600) begin step(); k++; end
      run_len = 0;
      while (outpins[0] && k < 1200) begin
         run_len++;
         if (run_len == 10) begin modify = 3'd1; addr = A_D0; wdata = 32'd200; end
         step(); modify = 3'd0; k++;
      end
      n_total++; if (run_len != 64) $display("FAIL glitch_current: got %0d expected 64", run_len); else n_pass++;
      measure_run(len);
      n_total++; if (len != 200) $display("FAIL glitch_next: got %0d expected 200", len); else n_pass++;
      k = 0;
      while (m_pos != 254 && k < 600) begin step(); k++; end
      csr(3'd1, A_D0, 32'd30);
      measure_run(len);
      n_total++; if (len != 200) $display("FAIL wrap_write_old: got %0d expected 200", len); else n_pass++;
      measure_run(len);
      n_total++; if (len != 30) $display("FAIL wrap_write_new: got %0d expected 30", len); else n_pass++;
      $display("test_glitch_free done");
   endtask

   task automatic test_random();
      int          mism_bus, mism_out;
      logic [2:0]  op;
      logic [11:0] a;
      logic [31:0] d;
      logic        ev;
      logic [31:0] er;
      mism_bus = 0; mism_out = 0;
      for (int c = 0; c < 4000; c++) begin
         a  = BASE - 12'd1 + 12'($urandom_range(0, 7));
         op = 3'd0;
         d  = $urandom;
         if ($urandom_range(0, 49) == 0) begin
            op = 3'($urandom_range(1, 4));
            if (a == A_PRE) begin
               d = d & 32'd3;
               if (m_run) op = 3'd0;
            end
            if (a == A_CTRL && op == 3'd1) d[16] = ($urandom_range(0, 3) != 0);
         end
         read = 1'($urandom_range(0, 1));
         addr = a; modify = op; wdata = d;
         #1;
         ev = m_hit(a) && (read || (op >= 3'd1 && op <= 3'd3));
         er = ev ? m_reg(a) : 32'd0;
         if (valid !== ev || rdata !== er) mism_bus++;
         step();
         modify = 3'd0;
         if (outpins !== m_out || period_irq !== m_irq) mism_out++;
      end
      n_total++; if (mism_bus != 0) $display("FAIL random_bus: got %0d mismatching cycles expected 0", mism_bus); else n_pass++;
      n_total++; if (mism_out != 0) $display("FAIL random_outputs: got %0d mismatching cycles expected 0", mism_out); else n_pass++;
      $display("test_random done");
   endtask

   task automatic test_reset_mid();
      csr(3'd1, A_CTRL, 32'd0);
      csr(3'd1, A_PRE, 32'd1);
      csr(3'd1, A_D2, 32'd255);
      csr(3'd1, A_CTRL, 32'h0003_000F);
      repeat (3) step();
      n_total++; if (outpins[2] !== 1'b1) $display("FAIL midreset_pre_high: got %b expected 1", outpins[2]); else n_pass++;
      rstn = 1'b0;
      step();
      n_total++; if (outpins !== '0) $display("FAIL midreset_outpins: got %b expected 0", outpins); else n_pass++;
      n_total++; if (period_irq !== 1'b0) $display("FAIL midreset_irq: got %b expected 0", period_irq); else n_pass++;
      read = 1'b1; addr = A_CTRL; #1;
      n_total++; if (rdata !== 32'd0) $display("FAIL midreset_ctrl: got %h expected 0", rdata); else n_pass++;
      addr = A_D2; #1;
      n_total++; if (rdata !== 32'd0) $display("FAIL midreset_duty: got %h expected 0", rdata); else n_pass++;
      addr = A_PRE; #1;
      n_total++; if (rdata !== 32'd0) $display("FAIL midreset_prescale: got %h expected 0", rdata); else n_pass++;
      rstn = 1'b1;
      step();
      $display("test_reset_mid done");
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      test_reset();
      test_csr_ops();
      test_duty();
      test_prescaler();
      test_glitch_free();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/csr_pwm_outpins.md
# csr_pwm_outpins

Parametrised CSR-mapped PWM output block for board wrappers; successor to the plain on/off LED register of the default CSR peripheral set. Drives CHANNELS output pins, each with an individual duty cycle, a shared programmable prescaler and glitch-free duty updates at period boundaries. Sits on the pipeline CSR bus beside the default CSR block; bus outputs are zero when not addressed, so `rdata`/`valid` of both blocks are OR-combined.

## Interface
- CHANNELS, 4: number of PWM outputs, 1..16.
- WIDTH, 8: duty/phase resolution in bits, 2..16.
- PRESCALE_WIDTH, 16: prescaler register width.
- BASE_ADDR, 12'hBC4: CSR address of CTRL; PRESCALE at BASE_ADDR+1; DUTY[i] at BASE_ADDR+2+i.
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- read  in  1  CSR read request.
- modify  in  3  CSR write op: 0 none, 1 write, 2 set bits, 3 clear bits, others none.
- wdata  in  32  CSR write operand.
- addr  in  12  CSR address.
- rdata  out  32  CSR read data (0 when not addressed).
- valid  out  1  addressed register exists.
- outpins  out  CHANNELS  PWM outputs.
- period_irq  out  1  one-cycle pulse at each period wrap while CTRL.IE=1.

## Operation
- CTRL: bits[CHANNELS-1:0] per-channel enable EN; bit 16 global run RUN; bit 17 interrupt enable IE; bits[31:24] read-only wrap counter WRAPS (8 bit, increments per period, wraps 255->0). Other bits read 0, writes ignored.
- PRESCALE (PRESCALE_WIDTH bits, zero-extended): tick every PRESCALE+1 clocks. Value 0 = tick every clock.
- DUTY[i] (WIDTH bits): shadow register. Active duty copied from shadow at period wrap only; readback returns shadow.
- Hit = addr in {BASE_ADDR .. BASE_ADDR+1+CHANNELS}. valid = hit & (read | modify in 1..3). rdata = current register value when valid, else 0.
- Write result: write -> wdata; set -> old | wdata; clear -> old & ~wdata; masked to implemented bits. Applied at rising edge of the cycle the op is presented.
- Prescaler counter counts down from PRESCALE; reaching 0 produces tick and reloads. Phase counter 0..2^WIDTH-2 (period 2^WIDTH-1 ticks) advances per tick; wrap from 2^WIDTH-2 to 0 = period wrap.
- outpins[i] = RUN & EN[i] & (phase < active_duty[i]), registered. Duty 0 -> constant 0; duty 2^WIDTH-1 -> constant 1.
- RUN=0: prescaler and phase held at 0, outputs 0, active duties continuously load from shadows, no wraps/irq.
- PRESCALE write reloads the prescaler counter immediately; phase not disturbed.

## Timing
- Reset (rstn=0 at clk edge): CTRL=0, PRESCALE=0, all DUTY shadow/active=0, phase=0, prescaler=0, WRAPS=0, outpins=0, period_irq=0. rdata/valid are combinational and follow bus inputs even in reset.
- CSR read: combinational, same cycle; read of register written in same cycle returns old value.
- outpins: one clock after the phase/duty state that determines them.
- Period wrap: active duties load, WRAPS increments, period_irq pulses (if IE) in the same edge the phase returns to 0; first output cycle of the new period uses new duty.
- DUTY write in the same cycle as period wrap: old shadow loaded into active; new value active from next wrap.
- RUN 0->1: first tick after PRESCALE+1 clocks; outputs of phase 0 visible one clock after RUN set.
- Simultaneous modify on CTRL and internal WRAPS increment: WRAPS increments, written bits apply to writable fields.

## Test plan
- Reset: hold rstn=0 2 cycles with read of BASE_ADDR -> rdata=0, valid=1, outpins=0, period_irq=0.
- CSR ops: write CTRL=0x0003_0005, set 0x2, clear 0x1 -> readback 0x0003_0006; read addr BASE_ADDR+2+CHANNELS -> valid=0, rdata=0.
- Duty: WIDTH=8, PRESCALE=0, DUTY[0]=64, EN[0]=RUN=1 -> outpins[0] high exactly 64 of every 255 clocks; DUTY 0 -> never high; 255 -> always high.
- Prescaler: PRESCALE=3, DUTY[1]=10 -> high 40 clocks per 1020-clock period; period_irq one pulse per 1020 clocks with IE=1, none with IE=0.
- Glitch-free update: write DUTY[0]=200 mid-period -> current period keeps old high length, next period 200; write on wrap cycle -> applies one period later.
- Reset mid-operation: assert rstn low while outputs high -> next edge outpins=0, WRAPS=0, registers cleared.
